// File: rtl/clod_pim_pkg.sv
// clod_pim_pkg: shared FSM state and request op encodings for the PiM LUT engine
package clod_pim_pkg;
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_e;
    localparam logic OP_LOOKUP = 1'b0;
    localparam logic OP_OFFSET = 1'b1;
endpackage

// File: rtl/clod_pim_lut_lane_sel.sv
// clod_pim_lut_lane_sel: combinational element select from the flattened LUT storage
module clod_pim_lut_lane_sel #(
    parameter int NUM_ENTRIES = 256,
    parameter int ELEM_W = 8,
    localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES*ELEM_W-1:0] entries,
    input  logic [IDX_W-1:0]              idx,
    output logic [ELEM_W-1:0]             data
);
    assign data = entries[idx*ELEM_W +: ELEM_W];
endmodule

// File: rtl/clod_pim_lut_engine.sv
// clod_pim_lut_engine: row-loaded multi-lane LUT with one-cycle registered lookups
module clod_pim_lut_engine
    import clod_pim_pkg::*;
#(
    parameter int NUM_ENTRIES = 256,
    parameter int ELEM_W = 8,
    parameter int LANES = 4,
    localparam int IDX_W = $clog2(NUM_ENTRIES),
    localparam int BEATS = NUM_ENTRIES / LANES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inv,
    input  logic                      row_valid,
    output logic                      row_ready,
    input  logic [LANES*ELEM_W-1:0]   row_data,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_op,
    input  logic [IDX_W-1:0]          req_base,
    input  logic [LANES*IDX_W-1:0]    req_idx,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [LANES*ELEM_W-1:0]   resp_data,
    output logic                      lut_ready
);
    localparam int BCW = BEATS > 1 ? $clog2(BEATS) : 1;

    state_e                        state_q, state_d;
    logic [BCW-1:0]                beat_cnt_q, beat_cnt_d;
    logic [NUM_ENTRIES*ELEM_W-1:0] mem_q, mem_d;
    logic                          resp_valid_q, resp_valid_d;
    logic [LANES*ELEM_W-1:0]       resp_data_q, resp_data_d;
    logic [LANES*ELEM_W-1:0]       sel;
    logic                          row_acc, req_acc, last_beat;

    assign row_ready  = (state_q != READY) && !inv;
    assign req_ready  = (state_q == READY) && !inv && (!resp_valid_q || resp_ready);
    assign row_acc    = row_valid && row_ready;
    assign req_acc    = req_valid && req_ready;
    assign last_beat  = beat_cnt_q == BCW'(BEATS - 1);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign lut_ready  = state_q == READY;

    // Per-lane effective index (wrap-around add in OFFSET mode) and element select
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0] idx_k, eff_k;
        assign idx_k = req_idx[k*IDX_W +: IDX_W];
        assign eff_k = (req_op == OP_OFFSET) ? idx_k + req_base : idx_k;
        clod_pim_lut_lane_sel #(
            .NUM_ENTRIES(NUM_ENTRIES),
            .ELEM_W(ELEM_W)
        ) u_sel (
            .entries(mem_q),
            .idx(eff_k),
            .data(sel[k*ELEM_W +: ELEM_W])
        );
    end

    // Load FSM: count accepted beats, go READY on the last one; inv always wins
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (inv) begin
            state_d    = EMPTY;
            beat_cnt_d = '0;
        end else if (row_acc) begin
            state_d    = last_beat ? READY : LOADING;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BCW'(1);
        end
    end

    // Storage write of one beat into its LANES-wide slot
    always_comb begin
        mem_d = mem_q;
        if (row_acc)
            mem_d[beat_cnt_q*LANES*ELEM_W +: LANES*ELEM_W] = row_data;
    end

    // Response register: load on accept, hold under backpressure
    always_comb begin
        resp_valid_d = req_acc || (resp_valid_q && !resp_ready);
        resp_data_d  = req_acc ? sel : resp_data_q;
    end

    // Control and response state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            beat_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // LUT storage is intentionally left unreset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
